// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared types and constants for the PS/2 host transmitter and
//            the keyboard receiver that sits next to it.
// Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

  // Transmitter sequencing states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_RTS     = 3'd2,
    ST_BITS    = 3'd3,
    ST_ACK     = 3'd4,
    ST_WAIT    = 3'd5
  } state_e;

  // Host-to-keyboard commands
  localparam logic [7:0] CMD_LEDS   = 8'hED;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;

  // Keyboard replies
  localparam logic [7:0] REP_ACK    = 8'hFA;
  localparam logic [7:0] REP_RESEND = 8'hFE;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_filter
// Brief    : 8-sample glitch filter on a PS/2 line with a falling-edge
//            strobe. The filtered level only changes once eight consecutive
//            ce samples agree.
// Revision : 1.0  initial release
// ============================================================================
module ps2_filter (
  input  logic clock,
  input  logic reset,
  input  logic ce_i,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [7:0] sh_q, sh_d;
  logic       level_q, level_d;

  // Next shift contents and the filtered level they imply
  always_comb begin
    sh_d    = {sh_q[6:0], line_i};
    level_d = level_q;
    if (sh_d == 8'hFF) begin
      level_d = 1'b1;
    end else if (sh_d == 8'h00) begin
      level_d = 1'b0;
    end
  end

  // Sample history and filtered level advance only on ce
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_q    <= 8'hFF;
      level_q <= 1'b1;
    end else if (ce_i) begin
      sh_q    <= sh_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  // Strobe in the same tick the filtered level is committed low
  assign fall_o  = ce_i & level_q & ~level_d;

endmodule
`default_nettype wire

// File: rtl/ps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_tx
// Brief    : PS/2 host-to-device transmitter. Inhibits the bus, issues
//            request-to-send, shifts data/parity/stop on device clock falls,
//            checks the device acknowledge and reports done or error.
// Revision : 1.0  initial release
// ============================================================================
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT = 400,
  parameter int TIMEOUT = 60000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  input  logic       txStrb,
  input  logic [7:0] txData,
  output logic       ps2ClkOe,
  output logic       ps2DatOe,
  output logic       txBusy,
  output logic       txDone,
  output logic       txErr
);

  localparam int IW = (INHIBIT > 1) ? $clog2(INHIBIT) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Counters hold "ticks already elapsed"; the limit is hit on the tick that
  // would make the elapsed count equal the parameter.
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic [3:0]    bit_q, bit_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          clkoe_q, clkoe_d;
  logic          datoe_q, datoe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          din_q, din_d;

  logic          w_level;
  logic          w_fall;
  logic          w_tmo_hit;

  ps2_filter u_clk_filter (
    .clock   (clock),
    .reset   (reset),
    .ce_i    (ce),
    .line_i  (ps2[0]),
    .level_o (w_level),
    .fall_o  (w_fall)
  );

  assign w_tmo_hit = (tmo_q == TMO_LAST);

  // Next-state, counters and line drive; everything holds when ce is low
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    par_d   = par_q;
    bit_d   = bit_q;
    inh_d   = inh_q;
    tmo_d   = tmo_q;
    clkoe_d = clkoe_q;
    datoe_d = datoe_q;
    busy_d  = busy_q;
    done_d  = done_q & ~ce;
    err_d   = err_q & ~ce;
    din_d   = ce ? ps2[1] : din_q;

    if (ce) begin
      case (state_q)
        ST_IDLE: begin
          if (txStrb) begin
            data_d  = txData;
            par_d   = odd_parity(txData);
            inh_d   = '0;
            tmo_d   = '0;
            clkoe_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (inh_q == INH_LAST) begin
            datoe_d = 1'b1;
            state_d = ST_RTS;
          end else begin
            inh_d = inh_q + IW'(1);
          end
        end

        default: begin
          // Timeout takes priority over any edge seen in the same tick
          if (w_tmo_hit) begin
            clkoe_d = 1'b0;
            datoe_d = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            if (tmo_q != '1) begin
              tmo_d = tmo_q + TW'(1);
            end
            case (state_q)
              ST_RTS: begin
                clkoe_d = 1'b0;
                bit_d   = 4'd0;
                tmo_d   = '0;
                state_d = ST_BITS;
              end
              ST_BITS: begin
                if (w_fall) begin
                  tmo_d = '0;
                  bit_d = bit_q + 4'd1;
                  if (bit_q < 4'd8) begin
                    datoe_d = ~data_q[bit_q[2:0]];
                  end else if (bit_q == 4'd8) begin
                    datoe_d = ~par_q;
                  end else begin
                    datoe_d = 1'b0;
                    state_d = ST_ACK;
                  end
                end
              end
              ST_ACK: begin
                if (w_fall) begin
                  if (!din_q) begin
                    state_d = ST_WAIT;
                  end else begin
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                  end
                end
              end
              ST_WAIT: begin
                if (w_level && din_q) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
                end
              end
              default: begin
                state_d = ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  // State and datapath registers; reset releases the lines regardless of ce
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= 8'h00;
      par_q   <= 1'b0;
      bit_q   <= 4'd0;
      inh_q   <= '0;
      tmo_q   <= '0;
      clkoe_q <= 1'b0;
      datoe_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      din_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      inh_q   <= inh_d;
      tmo_q   <= tmo_d;
      clkoe_q <= clkoe_d;
      datoe_q <= datoe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      din_q   <= din_d;
    end
  end

  assign ps2ClkOe = clkoe_q;
  assign ps2DatOe = datoe_q;
  assign txBusy   = busy_q;
  assign txDone   = done_q;
  assign txErr    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_tx
// Brief    : Directed bench for ps2_tx with a keyboard-side line model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int INH = 4;
  localparam int TMO = 200;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       ce      = 1'b0;
  logic       txStrb  = 1'b0;
  logic [7:0] txData  = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic [1:0] ps2;
  logic       ps2ClkOe, ps2DatOe, txBusy, txDone, txErr;

  int   tests = 0, fails = 0;
  int   tick_no = 0, done_cnt = 0, err_cnt = 0, err_tick = 0;
  logic done_busy = 1'b1;

  // Open-drain bus: either side can pull a line low
  assign ps2 = {dev_dat & ~ps2DatOe, dev_clk & ~ps2ClkOe};

  ps2_tx #(.INHIBIT(INH), .TIMEOUT(TMO)) dut (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .ps2      (ps2),
    .txStrb   (txStrb),
    .txData   (txData),
    .ps2ClkOe (ps2ClkOe),
    .ps2DatOe (ps2DatOe),
    .txBusy   (txBusy),
    .txDone   (txDone),
    .txErr    (txErr)
  );

  always #5 clock = ~clock;
  // ce is high on every other rising edge; it changes on falling edges
  always @(negedge clock) ce = ~ce;

  // Advance to just after the next ce edge and log the pulse outputs
  task automatic tick();
    @(posedge clock);
    while (!ce) @(posedge clock);
    #1;
    tick_no++;
    if (txDone) begin done_cnt++; done_busy = txBusy; end
    if (txErr)  begin err_cnt++;  err_tick  = tick_no; end
  endtask

  task automatic settle();
    dev_clk = 1'b1; dev_dat = 1'b1;
    repeat (12) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    txData = b; txStrb = 1'b1;
    tick();
    txStrb = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (txBusy && !ps2ClkOe && ps2DatOe) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!txBusy) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // Device generates n clock pulses and records the data line before each rise
  task automatic dev_clocks(input int n, output logic [10:0] bits);
    bits = '0;
    bits[0] = ps2[1];
    repeat (10) tick();
    for (int k = 0; k < n; k++) begin
      dev_clk = 1'b0;
      repeat (20) tick();
      bits[k+1] = ps2[1];
      dev_clk = 1'b1;
      repeat (20) tick();
    end
  endtask

  task automatic dev_ack(input bit pull_low);
    if (pull_low) dev_dat = 1'b0;
    repeat (2) tick();
    dev_clk = 1'b0;
    repeat (20) tick();
    dev_clk = 1'b1;
    dev_dat = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    tests++; if (ps2ClkOe !== 1'b0) begin fails++; $display("FAIL rst_clkoe: got %b expected 0", ps2ClkOe); end
    tests++; if (ps2DatOe !== 1'b0) begin fails++; $display("FAIL rst_datoe: got %b expected 0", ps2DatOe); end
    tests++; if (txBusy   !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", txBusy); end
    tests++; if (txDone   !== 1'b0) begin fails++; $display("FAIL rst_done: got %b expected 0", txDone); end
    tests++; if (txErr    !== 1'b0) begin fails++; $display("FAIL rst_err: got %b expected 0", txErr); end
    reset = 1'b0;
    settle();
  endtask

  task automatic test_send_leds();
    logic [10:0] bits;
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    send_byte(CMD_LEDS);
    tests++; if (txBusy !== 1'b1 || ps2ClkOe !== 1'b1 || ps2DatOe !== 1'b0) begin
      fails++; $display("FAIL accept: got busy=%b clk=%b dat=%b expected 1 1 0", txBusy, ps2ClkOe, ps2DatOe); end
    repeat (3) tick();
    tests++; if (ps2ClkOe !== 1'b1 || ps2DatOe !== 1'b0) begin
      fails++; $display("FAIL inhibit_hold: got clk=%b dat=%b expected 1 0", ps2ClkOe, ps2DatOe); end
    tick();
    tests++; if (ps2ClkOe !== 1'b1 || ps2DatOe !== 1'b1) begin
      fails++; $display("FAIL rts: got clk=%b dat=%b expected 1 1", ps2ClkOe, ps2DatOe); end
    tick();
    tests++; if (ps2ClkOe !== 1'b0 || ps2DatOe !== 1'b1) begin
      fails++; $display("FAIL release: got clk=%b dat=%b expected 0 1", ps2ClkOe, ps2DatOe); end
    dev_clocks(10, bits);
    dev_ack(1'b1);
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL leds_idle: got busy=%b expected 0", txBusy); end
    tests++; if (bits !== 11'b11_1110_1101_0) begin fails++; $display("FAIL leds_frame: got %b expected %b", bits, 11'b11_1110_1101_0); end
    tests++; if (done_cnt !== d0 + 1) begin fails++; $display("FAIL leds_done: got %0d expected %0d", done_cnt - d0, 1); end
    tests++; if (err_cnt !== e0) begin fails++; $display("FAIL leds_err: got %0d expected 0", err_cnt - e0); end
    tests++; if (done_busy !== 1'b0) begin fails++; $display("FAIL leds_busy_at_done: got %b expected 0", done_busy); end
    tests++; if (ps2ClkOe !== 1'b0 || ps2DatOe !== 1'b0) begin
      fails++; $display("FAIL leds_lines: got clk=%b dat=%b expected 0 0", ps2ClkOe, ps2DatOe); end
    settle();
  endtask

  task automatic test_send_enable();
    logic [10:0] bits;
    bit ok;
    int d0 = done_cnt;
    send_byte(CMD_ENABLE);
    wait_release(ok);
    tests++; if (!ok) begin fails++; $display("FAIL en_release: got clk=%b dat=%b expected 0 1", ps2ClkOe, ps2DatOe); end
    dev_clocks(10, bits);
    dev_ack(1'b1);
    wait_idle(ok);
    tests++; if (bits[9] !== 1'b0) begin fails++; $display("FAIL en_parity: got %b expected 0", bits[9]); end
    tests++; if (bits !== 11'b10_1111_0100_0) begin fails++; $display("FAIL en_frame: got %b expected %b", bits, 11'b10_1111_0100_0); end
    tests++; if (done_cnt !== d0 + 1) begin fails++; $display("FAIL en_done: got %0d expected 1", done_cnt - d0); end
    settle();
  endtask

  task automatic test_timeout();
    bit ok;
    int t0;
    int d0 = done_cnt, e0 = err_cnt;
    send_byte(CMD_LEDS);
    wait_release(ok);
    t0 = tick_no;
    for (int i = 0; i < 260; i++) begin
      if (err_cnt != e0) break;
      tick();
    end
    tests++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL tmo_err: got %0d expected 1", err_cnt - e0); end
    tests++; if (err_tick - t0 !== TMO) begin fails++; $display("FAIL tmo_latency: got %0d expected %0d", err_tick - t0, TMO); end
    tests++; if (ps2ClkOe !== 1'b0 || ps2DatOe !== 1'b0 || txBusy !== 1'b0) begin
      fails++; $display("FAIL tmo_lines: got clk=%b dat=%b busy=%b expected 0 0 0", ps2ClkOe, ps2DatOe, txBusy); end
    tests++; if (done_cnt !== d0) begin fails++; $display("FAIL tmo_done: got %0d expected 0", done_cnt - d0); end
    settle();
  endtask

  task automatic test_no_ack();
    logic [10:0] bits;
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    send_byte(CMD_RESET);
    wait_release(ok);
    dev_clocks(10, bits);
    tests++; if (err_cnt !== e0) begin fails++; $display("FAIL nack_early_err: got %0d expected 0", err_cnt - e0); end
    dev_ack(1'b0);
    tests++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL nack_err: got %0d expected 1", err_cnt - e0); end
    tests++; if (txBusy !== 1'b0 || ps2ClkOe !== 1'b0 || ps2DatOe !== 1'b0) begin
      fails++; $display("FAIL nack_idle: got busy=%b clk=%b dat=%b expected 0 0 0", txBusy, ps2ClkOe, ps2DatOe); end
    settle();
    tests++; if (done_cnt !== d0) begin fails++; $display("FAIL nack_done: got %0d expected 0", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    bit ok;
    int d0, e0;
    send_byte(CMD_ENABLE);
    wait_release(ok);
    dev_clocks(4, bits);
    // bit 3 of 0xF4 is 0, so the host is pulling data low here
    tests++; if (ps2DatOe !== 1'b1) begin fails++; $display("FAIL mid_pre_dat: got %b expected 1", ps2DatOe); end
    d0 = done_cnt; e0 = err_cnt;
    reset = 1'b1;
    @(posedge clock);
    #1;
    tests++; if (ps2ClkOe !== 1'b0 || ps2DatOe !== 1'b0 || txBusy !== 1'b0) begin
      fails++; $display("FAIL mid_reset_lines: got clk=%b dat=%b busy=%b ce=%b expected 0 0 0", ps2ClkOe, ps2DatOe, txBusy, ce); end
    reset = 1'b0;
    settle();
    tests++; if (err_cnt !== e0 || done_cnt !== d0) begin
      fails++; $display("FAIL mid_pulses: got err=%0d done=%0d expected 0 0", err_cnt - e0, done_cnt - d0); end
    send_byte(CMD_RESET);
    wait_release(ok);
    dev_clocks(10, bits);
    dev_ack(1'b1);
    wait_idle(ok);
    tests++; if (bits !== 11'b11_1111_1111_0) begin fails++; $display("FAIL mid_ff_frame: got %b expected %b", bits, 11'b11_1111_1111_0); end
    tests++; if (done_cnt !== d0 + 1) begin fails++; $display("FAIL mid_ff_done: got %0d expected 1", done_cnt - d0); end
    settle();
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    bit ok;
    int d0 = done_cnt;
    send_byte(CMD_LEDS);
    tick();
    send_byte(8'h55);
    wait_release(ok);
    dev_clocks(10, bits);
    dev_ack(1'b1);
    wait_idle(ok);
    tests++; if (bits !== 11'b11_1110_1101_0) begin fails++; $display("FAIL bp_frame: got %b expected %b", bits, 11'b11_1110_1101_0); end
    tests++; if (done_cnt !== d0 + 1) begin fails++; $display("FAIL bp_done: got %0d expected 1", done_cnt - d0); end
    repeat (20) tick();
    tests++; if (txBusy !== 1'b0 || ps2ClkOe !== 1'b0) begin
      fails++; $display("FAIL bp_no_queue: got busy=%b clk=%b expected 0 0", txBusy, ps2ClkOe); end
  endtask

  initial begin
    test_reset();
    test_send_leds();
    test_send_enable();
    test_timeout();
    test_no_ack();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
